// File: rtl/noc_params.sv
// Shared NoC parameters and flit types: mesh dimensions, address widths,
// flit labels and the head/body flit payload layout.
package noc_params;

    localparam int MESH_SIZE_X      = 8;
    localparam int MESH_SIZE_Y      = 4;
    localparam int DEST_ADDR_SIZE_X = 6;
    localparam int DEST_ADDR_SIZE_Y = 3;

    // Head payload is {user payload, src_x, src_y}
    localparam int HEAD_PL_SIZE   = 64 + DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y;
    localparam int FLIT_DATA_SIZE = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PL_SIZE;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        TAIL,
        HEADTAIL
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0] x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0] y_dest;
        logic [HEAD_PL_SIZE-1:0]     head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t flit_label;
        flit_data_t  data;
    } flit_novc_t;

endpackage

// File: rtl/noc_packetizer_credit_counter.sv
// Downstream credit counter: starts full, saturates at BUFFER_DEPTH, a
// simultaneous send and returned credit cancel out.
module noc_credit_counter #(
    parameter  int BUFFER_DEPTH = 4,
    localparam int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q != CNT_W'(BUFFER_DEPTH))) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= CNT_W'(BUFFER_DEPTH);
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/noc_packetizer.sv
// Turns a message (head fields + streamed body words) into credit-flow-controlled
// NoC flits. Optional destination range check enabled by NOC_PKT_DEST_CHECK_EN.
module noc_packetizer
    import noc_params::*;
#(
    parameter  int BUFFER_DEPTH = 4,
    parameter  int MAX_BODY_LEN = 15,
    localparam int LEN_W        = $clog2(MAX_BODY_LEN + 1),
    localparam int CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        msg_valid_i,
    output logic                        msg_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] msg_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] msg_y_dest_i,
    input  logic [DEST_ADDR_SIZE_X-1:0] msg_src_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] msg_src_y_i,
    input  logic [63:0]                 msg_pl_i,
    input  logic [LEN_W-1:0]            msg_body_len_i,
    input  logic                        body_valid_i,
    output logic                        body_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]   body_data_i,
    output flit_novc_t                  flit_o,
    output logic                        valid_o,
    input  logic                        credit_i,
    output logic                        error_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY,
        ST_DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic [DEST_ADDR_SIZE_X-1:0] x_q, x_d;
    logic [DEST_ADDR_SIZE_Y-1:0] y_q, y_d;
    logic [HEAD_PL_SIZE-1:0]     head_pl_q, head_pl_d;
    logic [LEN_W-1:0]            remain_q, remain_d;
    flit_novc_t                  flit_q, flit_d;
    logic                        valid_q, valid_d;
    logic                        error_q, error_d;

    logic             send;
    logic [CNT_W-1:0] credit_cnt;
    logic             have_credit;
    logic [LEN_W-1:0] len_clamped;

    noc_credit_counter #(
        .BUFFER_DEPTH(BUFFER_DEPTH)
    ) u_credit_counter (
        .clk  (clk),
        .rst  (rst),
        .dec  (send),
        .inc  (credit_i),
        .count(credit_cnt)
    );

    assign have_credit = (credit_cnt != '0);
    assign len_clamped = (msg_body_len_i > LEN_W'(MAX_BODY_LEN)) ? LEN_W'(MAX_BODY_LEN)
                                                                  : msg_body_len_i;
    assign msg_ready_o = (state_q == ST_IDLE);

`ifdef NOC_PKT_DEST_CHECK_EN
    assign body_ready_o = ((state_q == ST_BODY) && have_credit) || (state_q == ST_DRAIN);
`else
    assign body_ready_o = (state_q == ST_BODY) && have_credit;
`endif

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        head_pl_d = head_pl_q;
        remain_d  = remain_q;
        flit_d    = flit_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        send      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (msg_valid_i) begin
                    x_d       = msg_x_dest_i;
                    y_d       = msg_y_dest_i;
                    head_pl_d = {msg_pl_i, msg_src_x_i, msg_src_y_i};
                    remain_d  = len_clamped;
                    state_d   = ST_HEAD;
`ifdef NOC_PKT_DEST_CHECK_EN
                    // Out-of-mesh destinations are accepted but only drained
                    if ((int'(msg_x_dest_i) >= MESH_SIZE_X) ||
                        (int'(msg_y_dest_i) >= MESH_SIZE_Y)) begin
                        error_d = 1'b1;
                        state_d = (len_clamped == '0) ? ST_IDLE : ST_DRAIN;
                    end
`endif
                end
            end
            ST_HEAD: begin
                if (have_credit) begin
                    send                        = 1'b1;
                    valid_d                     = 1'b1;
                    flit_d.flit_label           = (remain_q == '0) ? HEADTAIL : HEAD;
                    flit_d.data.head_data.x_dest  = x_q;
                    flit_d.data.head_data.y_dest  = y_q;
                    flit_d.data.head_data.head_pl = head_pl_q;
                    state_d                     = (remain_q == '0) ? ST_IDLE : ST_BODY;
                end
            end
            ST_BODY: begin
                if (have_credit && body_valid_i) begin
                    send              = 1'b1;
                    valid_d           = 1'b1;
                    flit_d.flit_label = (remain_q == LEN_W'(1)) ? TAIL : BODY;
                    flit_d.data.bt_pl = body_data_i;
                    remain_d          = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
`ifdef NOC_PKT_DEST_CHECK_EN
                if (body_valid_i) begin
                    remain_d = remain_q - LEN_W'(1);
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            head_pl_q <= '0;
            remain_q  <= '0;
            flit_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            head_pl_q <= head_pl_d;
            remain_q  <= remain_d;
            flit_q    <= flit_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign flit_o  = flit_q;
    assign valid_o = valid_q;
    assign error_o = error_q;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed self-checking bench for noc_packetizer (default BUFFER_DEPTH=4).
// Destination-check scenario is selected by NOC_PKT_DEST_CHECK_EN.
module tb_noc_packetizer;
    import noc_params::*;

    localparam int BUFFER_DEPTH = 4;
    localparam int MAX_BODY_LEN = 15;
    localparam int LEN_W        = $clog2(MAX_BODY_LEN + 1);

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        msg_valid_i = 1'b0;
    logic                        msg_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0] msg_x_dest_i = '0;
    logic [DEST_ADDR_SIZE_Y-1:0] msg_y_dest_i = '0;
    logic [DEST_ADDR_SIZE_X-1:0] msg_src_x_i = '0;
    logic [DEST_ADDR_SIZE_Y-1:0] msg_src_y_i = '0;
    logic [63:0]                 msg_pl_i = '0;
    logic [LEN_W-1:0]            msg_body_len_i = '0;
    logic                        body_valid_i = 1'b0;
    logic                        body_ready_o;
    logic [FLIT_DATA_SIZE-1:0]   body_data_i = '0;
    flit_novc_t                  flit_o;
    logic                        valid_o;
    logic                        credit_i = 1'b0;
    logic                        error_o;

    always #5 clk = ~clk;

    noc_packetizer #(
        .BUFFER_DEPTH(BUFFER_DEPTH),
        .MAX_BODY_LEN(MAX_BODY_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .msg_valid_i   (msg_valid_i),
        .msg_ready_o   (msg_ready_o),
        .msg_x_dest_i  (msg_x_dest_i),
        .msg_y_dest_i  (msg_y_dest_i),
        .msg_src_x_i   (msg_src_x_i),
        .msg_src_y_i   (msg_src_y_i),
        .msg_pl_i      (msg_pl_i),
        .msg_body_len_i(msg_body_len_i),
        .body_valid_i  (body_valid_i),
        .body_ready_o  (body_ready_o),
        .body_data_i   (body_data_i),
        .flit_o        (flit_o),
        .valid_o       (valid_o),
        .credit_i      (credit_i),
        .error_o       (error_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: flits, handshakes and error pulses sampled on the falling edge
    int         cyc = 0;
    flit_novc_t fq[$];
    int         fcyc[$];
    int         hs_cyc  = 0;
    int         err_n   = 0;
    int         err_cyc = 0;
    int         body_n  = 0;
    logic       feed_hs = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid_o) begin
            fq.push_back(flit_o);
            fcyc.push_back(cyc);
        end
        if (msg_valid_i && msg_ready_o) hs_cyc = cyc;
        if (error_o) begin
            err_n++;
            err_cyc = cyc;
        end
        feed_hs = body_valid_i && body_ready_o;
        if (feed_hs) body_n++;
    end

    // Body word source: advances one word per accepted handshake
    logic                      feed_on = 1'b0;
    int                        feed_idx = 0;
    int                        feed_n = 0;
    logic [FLIT_DATA_SIZE-1:0] feed_data [8];

    always @(posedge clk) begin
        #1;
        if (feed_hs) feed_idx++;
        body_valid_i = feed_on && (feed_idx < feed_n);
        body_data_i  = (feed_idx < 8) ? feed_data[feed_idx] : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_mon();
        fq.delete();
        fcyc.delete();
        err_n  = 0;
        body_n = 0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        feed_on = 1'b0;
        tick();
        rst = 1'b0;
        feed_idx = 0;
        feed_n   = 0;
    endtask

    task automatic feed_setup(input int n, input logic [FLIT_DATA_SIZE-1:0] base);
        feed_on  = 1'b0;
        feed_idx = 0;
        feed_n   = n;
        for (int i = 0; i < 8; i++) feed_data[i] = base + FLIT_DATA_SIZE'(i);
        feed_on = 1'b1;
    endtask

    task automatic send_msg(input int x, input int y, input int sx, input int sy,
                            input logic [63:0] pl, input int len);
        int waited;
        msg_x_dest_i   = DEST_ADDR_SIZE_X'(x);
        msg_y_dest_i   = DEST_ADDR_SIZE_Y'(y);
        msg_src_x_i    = DEST_ADDR_SIZE_X'(sx);
        msg_src_y_i    = DEST_ADDR_SIZE_Y'(sy);
        msg_pl_i       = pl;
        msg_body_len_i = LEN_W'(len);
        msg_valid_i    = 1'b1;
        waited = 0;
        while (!msg_ready_o && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check_eq("msg_handshake_timeout", 1, 0);
        tick();
        msg_valid_i = 1'b0;
    endtask

    function automatic flit_novc_t get_flit(input int i);
        if (i < fq.size()) return fq[i];
        return '0;
    endfunction

    function automatic int get_fcyc(input int i);
        if (i < fcyc.size()) return fcyc[i];
        return -100;
    endfunction

    function automatic flit_novc_t mk_head(input flit_label_t l, input int x, input int y,
                                           input logic [63:0] pl, input int sx, input int sy);
        flit_novc_t f;
        f = '0;
        f.flit_label             = l;
        f.data.head_data.x_dest  = DEST_ADDR_SIZE_X'(x);
        f.data.head_data.y_dest  = DEST_ADDR_SIZE_Y'(y);
        f.data.head_data.head_pl = {pl, DEST_ADDR_SIZE_X'(sx), DEST_ADDR_SIZE_Y'(sy)};
        return f;
    endfunction

    function automatic flit_novc_t mk_bt(input flit_label_t l, input logic [FLIT_DATA_SIZE-1:0] d);
        flit_novc_t f;
        f.flit_label = l;
        f.data.bt_pl = d;
        return f;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [63:0]               PL1 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0]               PL2 = 64'h0F0E_0D0C_0B0A_0908;
    localparam logic [FLIT_DATA_SIZE-1:0] WA  = 82'h0A0;
    localparam logic [FLIT_DATA_SIZE-1:0] WD  = 82'h3_0000_0000_0000_00D0;

    initial begin
        flit_novc_t f;
        logic [HEAD_PL_SIZE-1:0] hp;

        tick();
        tick();
        rst = 1'b0;

        check_eq("reset_valid", valid_o, 0);
        check_eq("reset_flit", flit_o, 0);
        check_eq("reset_error", error_o, 0);
        check_eq("reset_msg_ready", msg_ready_o, 1);
        check_eq("reset_body_ready", body_ready_o, 0);

        // Single HEADTAIL flit, 2-cycle latency
        clear_mon();
        send_msg(3, 2, 1, 5, PL1, 0);
        wait_cycles(4);
        check_eq("ht_count", fq.size(), 1);
        check_eq("ht_flit", get_flit(0), mk_head(HEADTAIL, 3, 2, PL1, 1, 5));
        f  = get_flit(0);
        hp = f.data.head_data.head_pl;
        check_eq("ht_head_pl_msg", hp[72:9], PL1);
        check_eq("ht_latency", get_fcyc(0) - hs_cyc, 2);

        // len=3 body streamed continuously
        do_reset();
        clear_mon();
        feed_setup(3, WA);
        tick();
        send_msg(5, 1, 2, 3, PL2, 3);
        wait_cycles(8);
        check_eq("stream_count", fq.size(), 4);
        check_eq("stream_head", get_flit(0), mk_head(HEAD, 5, 1, PL2, 2, 3));
        check_eq("stream_body0", get_flit(1), mk_bt(BODY, WA));
        check_eq("stream_body1", get_flit(2), mk_bt(BODY, WA + 1));
        check_eq("stream_tail", get_flit(3), mk_bt(TAIL, WA + 2));
        check_eq("stream_back_to_back", get_fcyc(3) - get_fcyc(0), 3);
        check_eq("stream_words_used", body_n, 3);
        check_eq("stream_idle_ready", msg_ready_o, 1);

        // Credit stall: two credits used up front leave two for a len=3 packet
        do_reset();
        clear_mon();
        send_msg(1, 1, 0, 0, PL1, 0);
        wait_cycles(2);
        send_msg(2, 1, 0, 0, PL1, 0);
        wait_cycles(3);
        check_eq("stall_pre_count", fq.size(), 2);
        clear_mon();
        feed_setup(3, WA);
        tick();
        send_msg(4, 3, 7, 6, PL2, 3);
        wait_cycles(8);
        check_eq("stall_count", fq.size(), 2);
        check_eq("stall_head", get_flit(0), mk_head(HEAD, 4, 3, PL2, 7, 6));
        check_eq("stall_body0", get_flit(1), mk_bt(BODY, WA));
        check_eq("stall_words_used", body_n, 1);
        check_eq("stall_body_ready", body_ready_o, 0);
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        wait_cycles(4);
        check_eq("stall_credit1_count", fq.size(), 3);
        check_eq("stall_body1", get_flit(2), mk_bt(BODY, WA + 1));
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        wait_cycles(4);
        check_eq("stall_credit2_count", fq.size(), 4);
        check_eq("stall_tail", get_flit(3), mk_bt(TAIL, WA + 2));

        // Credit returned in the same cycle as a send at count 1
        do_reset();
        clear_mon();
        feed_setup(4, WD);
        tick();
        send_msg(6, 0, 1, 1, PL1, 4);
        tick();
        tick();
        tick();
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        wait_cycles(4);
        check_eq("coinc_count", fq.size(), 5);
        check_eq("coinc_body2", get_flit(3), mk_bt(BODY, WD + 2));
        check_eq("coinc_tail", get_flit(4), mk_bt(TAIL, WD + 3));
        check_eq("coinc_no_stall", get_fcyc(4) - get_fcyc(0), 4);
        clear_mon();
        send_msg(1, 2, 3, 4, PL2, 0);
        wait_cycles(5);
        check_eq("zero_credit_no_send", fq.size(), 0);
        credit_i = 1'b1;
        tick();
        credit_i = 1'b0;
        wait_cycles(4);
        check_eq("zero_credit_resume", get_flit(0), mk_head(HEADTAIL, 1, 2, PL2, 3, 4));

`ifdef NOC_PKT_DEST_CHECK_EN
        // Out-of-range destination: error pulse, body drained, no flits
        do_reset();
        clear_mon();
        feed_setup(2, WA);
        tick();
        send_msg(40, 1, 0, 0, PL1, 2);
        wait_cycles(6);
        check_eq("dest_err_pulses", err_n, 1);
        check_eq("dest_err_timing", err_cyc - hs_cyc, 1);
        check_eq("dest_words_drained", body_n, 2);
        check_eq("dest_no_flits", fq.size(), 0);
        check_eq("dest_back_idle", msg_ready_o, 1);
`else
        // No range check: x=40 is forwarded and error_o stays low
        do_reset();
        clear_mon();
        send_msg(40, 1, 0, 0, PL1, 0);
        wait_cycles(4);
        check_eq("nocheck_err", err_n, 0);
        check_eq("nocheck_flit", get_flit(0), mk_head(HEADTAIL, 40, 1, PL1, 0, 0));
`endif

        // Reset right after the head of a len=5 packet
        do_reset();
        clear_mon();
        send_msg(2, 2, 1, 1, PL2, 5);
        tick();
        check_eq("midrst_head_seen", valid_o, 1);
        check_eq("midrst_body_ready_pre", body_ready_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_valid", valid_o, 0);
        check_eq("midrst_body_ready", body_ready_o, 0);
        check_eq("midrst_msg_ready", msg_ready_o, 1);
        check_eq("midrst_flit", flit_o, 0);
        feed_setup(5, WA);
        wait_cycles(6);
        check_eq("midrst_flits", fq.size(), 1);
        check_eq("midrst_words", body_n, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/noc_packetizer.md
NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 SHALL have parameter BUFFER_DEPTH, default 4: downstream input-buffer depth and initial credit count.
REQ-002 SHALL have parameter MAX_BODY_LEN, default 15: maximum number of body flits per packet.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge), then rst input 1.
REQ-004 msg_valid_i  input  1  message offered.
REQ-005 msg_ready_o  output  1  message accepted when high together with msg_valid_i.
REQ-006 msg_x_dest_i / msg_y_dest_i  input  DEST_ADDR_SIZE_X / DEST_ADDR_SIZE_Y  destination coordinates.
REQ-007 msg_src_x_i / msg_src_y_i  input  DEST_ADDR_SIZE_X / DEST_ADDR_SIZE_Y  source coordinates.
REQ-008 msg_pl_i  input  64  head user payload.
REQ-009 msg_body_len_i  input  $clog2(MAX_BODY_LEN+1)  number of body flits that follow.
REQ-010 body_valid_i / body_ready_o / body_data_i  input / output / input  1 / 1 / FLIT_DATA_SIZE  body-word handshake.
REQ-011 flit_o  output  flit_novc_t  outgoing flit.
REQ-012 valid_o  output  1  flit_o valid for exactly this cycle.
REQ-013 credit_i  input  1  one downstream buffer slot freed.
REQ-014 error_o  output  1  one-cycle pulse for a rejected message (only when NOC_PKT_DEST_CHECK_EN is defined).

Function
REQ-015 SHALL implement FSM IDLE -> HEAD -> (BODY ->) IDLE.
REQ-016 In IDLE, msg_ready_o SHALL be 1; on handshake, message fields are registered and the FSM enters HEAD.
REQ-017 Head flit:
- head_pl = {msg_pl, src_x, src_y}.
- flit_label = HEADTAIL if body_len==0, else HEAD.
REQ-018 Send decision:
- HEAD state: credit_cnt>0.
- BODY state: credit_cnt>0 && body_valid_i.
- body_ready_o = (state==BODY && credit_cnt>0), combinational.
REQ-019 flit_o/valid_o SHALL be registered: a send decision in cycle t gives valid_o=1 in cycle t+1, otherwise valid_o=0.
REQ-020 Minimum latency from message handshake to head flit on valid_o SHALL be 2 cycles.
REQ-021 Body flits carry bt_pl=body_data_i; labels are BODY, with the last one TAIL.
REQ-022 After the head, the FSM SHALL go to IDLE if body_len==0, else to BODY.
REQ-023 After the TAIL flit is sent, the FSM SHALL return to IDLE; the next message may be accepted the following cycle.
REQ-024 Body flits sent SHALL equal the registered body_len; no body handshake occurs outside BODY.
REQ-025 Credit counter, width $clog2(BUFFER_DEPTH+1):
- decrement on send, increment on credit_i;
- both in the same cycle leaves it unchanged;
- saturates at BUFFER_DEPTH;
- no send when it is 0.
REQ-026 msg_body_len_i > MAX_BODY_LEN SHALL be clamped to MAX_BODY_LEN.

Reset
REQ-027 On rst:
- state=IDLE, credit_cnt=BUFFER_DEPTH;
- valid_o=0, flit_o=0, error_o=0, msg_ready_o=1 in the following cycle.
REQ-028 Reset mid-packet SHALL abandon the packet without further flits; the remaining body words are not consumed.

Configuration
REQ-029 With NOC_PKT_DEST_CHECK_EN defined:
- a message with x_dest>=MESH_SIZE_X or y_dest>=MESH_SIZE_Y is accepted, and error_o pulses in the cycle after the handshake;
- no flits are emitted for it;
- its body_len body words are consumed, at one per cycle when valid and regardless of credits, and discarded;
- the FSM then returns to IDLE.
REQ-030 Without NOC_PKT_DEST_CHECK_EN, no range check is performed and error_o is tied to 0.

Structure
REQ-031 flit_novc_t, flit_label_t, head_data_t and the MESH/DEST constants SHALL come from noc_params; no new package types.
REQ-032 Credit counter SHALL be sub-module noc_credit_counter (inputs: dec, inc; output: count).

Verification
REQ-033 msg x=3,y=2,len=0, credits=4 -> single HEADTAIL flit, valid_o 2 cycles after the handshake, head_pl[72:9]=msg_pl.
REQ-034 len=3, body words A,B,C streamed continuously -> HEAD, BODY(A), BODY(B), TAIL(C) on consecutive cycles.
REQ-035 BUFFER_DEPTH=2, no credit_i, len=3 -> HEAD and BODY only, then stall; one credit_i -> next BODY; a second credit_i -> TAIL.
REQ-036 credit_i coincident with a send when credit_cnt=1 -> count stays 1 and the next flit is not stalled.
REQ-037 With the macro, x_dest=40, len=2 -> error_o one pulse, 2 body words consumed, valid_o never asserted.
REQ-038 rst asserted after the HEAD of a len=5 packet -> valid_o=0 and body_ready_o=0 from the next cycle, msg_ready_o=1.
